register_file_rename: RTL and testbench

Architectural register file with per-register rename tags. It sits between the decoder and the reorder buffer. Decoder source reads return either a committed value or the ROB tag of the in-flight producer. At issue, the destination register is tagged with the new ROB entry; at commit, the ROB writes the value and clears the tag only if it still matches. On rollback every tag is dropped and committed values are kept.

---
 rtl/register_file_rename_pkg.sv | 25 ++
 rtl/register_file_rename_read_port.sv | 60 ++++++
 rtl/register_file_rename.sv | 103 ++++++++++
 tb/tb_register_file_rename.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/register_file_rename_pkg.sv
// Shared constants for the rename register file and the reorder buffer.
// Word width, register index width, ROB tag width and the reserved
// NULL_TAG (tag 0 = no in-flight producer) all live here so the
// register file and the ROB always agree on field sizes.
package register_file_rename_pkg;

    localparam int WORD_W      = 32;
    localparam int REG_INDEX_W = 5;
    localparam int REG_COUNT   = 32;
    localparam int ROB_TAG_W   = 4;

    typedef logic [WORD_W-1:0]      word_t;
    typedef logic [REG_INDEX_W-1:0] reg_index_t;
    typedef logic [ROB_TAG_W-1:0]   rob_tag_t;

    localparam rob_tag_t   NULL_TAG       = '0;
    localparam word_t      ZERO_WORD      = '0;
    localparam reg_index_t ZERO_REG_INDEX = '0;

    // True when a register index names a real, writable register (not x0)
    function automatic logic is_writable_reg(input reg_index_t idx);
        return idx != ZERO_REG_INDEX;
    endfunction

endpackage

// File: rtl/register_file_rename_read_port.sv
// rf_read_port: one decoder source-operand port of the rename register file.
// Returns the stored value/tag of the selected register, with x0 forced to
// zero / NULL_TAG. When REGFILE_COMMIT_BYPASS_EN is defined, a commit
// landing on the selected register in the same cycle (and still owning its
// tag) is forwarded so the decoder sees the committed value immediately.
module rf_read_port
    import register_file_rename_pkg::*;
(
    input  logic [REG_INDEX_W-1:0] rs_index,
    input  logic [WORD_W-1:0]      stored_value,
    input  logic [ROB_TAG_W-1:0]   stored_tag,
    input  logic                   commit_valid,
    input  logic [REG_INDEX_W-1:0] commit_target,
    input  logic [ROB_TAG_W-1:0]   commit_tag,
    input  logic [WORD_W-1:0]      commit_data,
    output logic [WORD_W-1:0]      value,
    output logic [ROB_TAG_W-1:0]   tag
);

`ifdef REGFILE_COMMIT_BYPASS_EN
    logic bypass_hit;

    // A commit to this register forwards only if it is still the live producer
    always_comb begin
        bypass_hit = commit_valid
                  && is_writable_reg(rs_index)
                  && (commit_target == rs_index)
                  && (stored_tag == commit_tag);
    end

    // Select forwarded commit result, x0 constant, or stored state
    always_comb begin
        value = stored_value;
        tag   = stored_tag;
        if (!is_writable_reg(rs_index)) begin
            value = ZERO_WORD;
            tag   = NULL_TAG;
        end else if (bypass_hit) begin
            value = commit_data;
            tag   = NULL_TAG;
        end
    end
`else
    logic unused_bypass_inputs;

    // Commit inputs are only consumed by the bypass build
    assign unused_bypass_inputs = ^{commit_valid, commit_target, commit_tag, commit_data};

    // Select x0 constant or stored state
    always_comb begin
        value = stored_value;
        tag   = stored_tag;
        if (!is_writable_reg(rs_index)) begin
            value = ZERO_WORD;
            tag   = NULL_TAG;
        end
    end
`endif

endmodule

// File: rtl/register_file_rename.sv
// register_file_rename: architectural register file with per-register
// rename tags, between the decoder and the reorder buffer.
//  - Issue tags the destination with the new ROB entry.
//  - Commit always writes the value; it clears the tag only if the tag
//    still names the committing entry (a newer producer keeps ownership).
//  - Rollback drops every tag but keeps committed values.
// Widths come from register_file_rename_pkg (ROB_TAG_W, REG_COUNT).
// Optional macro REGFILE_COMMIT_BYPASS_EN forwards same-cycle commits to
// the read ports (see rf_read_port).
module register_file_rename
    import register_file_rename_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rollback_in,

    input  logic [REG_INDEX_W-1:0] dec_rs1_in,
    input  logic [REG_INDEX_W-1:0] dec_rs2_in,
    output logic [WORD_W-1:0]      dec_Vj_out,
    output logic [ROB_TAG_W-1:0]   dec_Qj_out,
    output logic [WORD_W-1:0]      dec_Vk_out,
    output logic [ROB_TAG_W-1:0]   dec_Qk_out,

    input  logic                   dec_issue_in,
    input  logic [REG_INDEX_W-1:0] dec_rd_in,
    input  logic [ROB_TAG_W-1:0]   dec_rd_tag_in,

    input  logic                   commit_rf_signal_in,
    input  logic [ROB_TAG_W-1:0]   commit_tag_in,
    input  logic [WORD_W-1:0]      commit_data_in,
    input  logic [REG_INDEX_W-1:0] commit_target_in
);

    logic [WORD_W-1:0]    value_q [REG_COUNT];
    logic [ROB_TAG_W-1:0] tag_q   [REG_COUNT];

    logic issue_en;
    logic commit_en;
    logic commit_owns_tag;

    // Decode which updates take effect this cycle
    always_comb begin
        issue_en        = dec_issue_in && is_writable_reg(dec_rd_in) && !rollback_in;
        commit_en       = commit_rf_signal_in && is_writable_reg(commit_target_in);
        commit_owns_tag = commit_en && (tag_q[commit_target_in] == commit_tag_in);
    end

    // Value storage: cleared on reset, written only by commit, untouched by rollback
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                value_q[i] <= ZERO_WORD;
            end
        end else if (commit_en) begin
            value_q[commit_target_in] <= commit_data_in;
        end
    end

    // Tag storage: rollback clears all, commit releases its own tag, issue claims (issue wins)
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                tag_q[i] <= NULL_TAG;
            end
        end else if (rollback_in) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                tag_q[i] <= NULL_TAG;
            end
        end else begin
            if (commit_owns_tag) begin
                tag_q[commit_target_in] <= NULL_TAG;
            end
            if (issue_en) begin
                tag_q[dec_rd_in] <= dec_rd_tag_in;
            end
        end
    end

    rf_read_port u_read_rs1 (
        .rs_index      (dec_rs1_in),
        .stored_value  (value_q[dec_rs1_in]),
        .stored_tag    (tag_q[dec_rs1_in]),
        .commit_valid  (commit_rf_signal_in),
        .commit_target (commit_target_in),
        .commit_tag    (commit_tag_in),
        .commit_data   (commit_data_in),
        .value         (dec_Vj_out),
        .tag           (dec_Qj_out)
    );

    rf_read_port u_read_rs2 (
        .rs_index      (dec_rs2_in),
        .stored_value  (value_q[dec_rs2_in]),
        .stored_tag    (tag_q[dec_rs2_in]),
        .commit_valid  (commit_rf_signal_in),
        .commit_target (commit_target_in),
        .commit_tag    (commit_tag_in),
        .commit_data   (commit_data_in),
        .value         (dec_Vk_out),
        .tag           (dec_Qk_out)
    );

endmodule

// File: tb/tb_register_file_rename.sv
// Directed bench for register_file_rename: reset, issue/commit tagging,
// stale commits, same-cycle issue+commit, x0 protection, rollback and
// the optional commit bypass.
module tb_register_file_rename;

    logic        clk = 1'b0;
    logic        rst;
    logic        rollback_in;
    logic [4:0]  dec_rs1_in;
    logic [4:0]  dec_rs2_in;
    logic [31:0] dec_Vj_out;
    logic [3:0]  dec_Qj_out;
    logic [31:0] dec_Vk_out;
    logic [3:0]  dec_Qk_out;
    logic        dec_issue_in;
    logic [4:0]  dec_rd_in;
    logic [3:0]  dec_rd_tag_in;
    logic        commit_rf_signal_in;
    logic [3:0]  commit_tag_in;
    logic [31:0] commit_data_in;
    logic [4:0]  commit_target_in;

    int test_count = 0;
    int fail_count = 0;

    register_file_rename dut (
        .clk                 (clk),
        .rst                 (rst),
        .rollback_in         (rollback_in),
        .dec_rs1_in          (dec_rs1_in),
        .dec_rs2_in          (dec_rs2_in),
        .dec_Vj_out          (dec_Vj_out),
        .dec_Qj_out          (dec_Qj_out),
        .dec_Vk_out          (dec_Vk_out),
        .dec_Qk_out          (dec_Qk_out),
        .dec_issue_in        (dec_issue_in),
        .dec_rd_in           (dec_rd_in),
        .dec_rd_tag_in       (dec_rd_tag_in),
        .commit_rf_signal_in (commit_rf_signal_in),
        .commit_tag_in       (commit_tag_in),
        .commit_data_in      (commit_data_in),
        .commit_target_in    (commit_target_in)
    );

    always #5 clk = ~clk;

    // Drive one cycle's worth of inputs and let the combinational reads settle
    task automatic applyStimulus(
        input logic       roll,
        input logic       issue, input logic [4:0] rd, input logic [3:0] rd_tag,
        input logic       commit, input logic [4:0] target, input logic [3:0] ctag,
        input logic [31:0] cdata,
        input logic [4:0] rs1, input logic [4:0] rs2);
        rollback_in         = roll;
        dec_issue_in        = issue;
        dec_rd_in           = rd;
        dec_rd_tag_in       = rd_tag;
        commit_rf_signal_in = commit;
        commit_target_in    = target;
        commit_tag_in       = ctag;
        commit_data_in      = cdata;
        dec_rs1_in          = rs1;
        dec_rs2_in          = rs2;
        #1;
    endtask

    // Read-only cycle: idle controls, only select source registers
    task automatic readRegs(input logic [4:0] rs1, input logic [4:0] rs2);
        applyStimulus(1'b0, 1'b0, 5'd0, 4'd0, 1'b0, 5'd0, 4'd0, 32'h0, rs1, rs2);
    endtask

    // Advance past the next rising edge and sample away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] observed,
                               input logic [31:0] expected);
        test_count++;
        assert (observed === expected)
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", name, observed, expected);
        end
    endtask

    initial begin
        // Reset cycle with every other input active; all must be ignored
        rst = 1'b1;
        applyStimulus(1'b1, 1'b1, 5'd5, 4'd3, 1'b1, 5'd5, 4'd3, 32'hAAAA_5555, 5'd5, 5'd0);
        tick();
        tick();
        rst = 1'b0;
        readRegs(5'd5, 5'd0);
        checkOutput("reset_Vj_x5", dec_Vj_out, 32'h0);
        checkOutput("reset_Qj_x5", {28'h0, dec_Qj_out}, 32'h0);
        checkOutput("reset_Vk_x0", dec_Vk_out, 32'h0);
        checkOutput("reset_Qk_x0", {28'h0, dec_Qk_out}, 32'h0);

        // Issue x3 tag 7; a same-cycle read of x3 sees the pre-issue tag
        applyStimulus(1'b0, 1'b1, 5'd3, 4'd7, 1'b0, 5'd0, 4'd0, 32'h0, 5'd3, 5'd0);
        checkOutput("issue_same_cycle_Qj", {28'h0, dec_Qj_out}, 32'h0);
        tick();
        readRegs(5'd3, 5'd0);
        checkOutput("issue_x3_Qj", {28'h0, dec_Qj_out}, 32'd7);
        applyStimulus(1'b0, 1'b0, 5'd0, 4'd0, 1'b1, 5'd3, 4'd7, 32'hDEAD_BEEF, 5'd0, 5'd0);
        tick();
        readRegs(5'd3, 5'd0);
        checkOutput("commit_x3_Vj", dec_Vj_out, 32'hDEAD_BEEF);
        checkOutput("commit_x3_Qj", {28'h0, dec_Qj_out}, 32'h0);

        // Two producers on x4; the stale commit writes value but keeps newer tag
        applyStimulus(1'b0, 1'b1, 5'd4, 4'd2, 1'b0, 5'd0, 4'd0, 32'h0, 5'd0, 5'd0);
        tick();
        applyStimulus(1'b0, 1'b1, 5'd4, 4'd5, 1'b0, 5'd0, 4'd0, 32'h0, 5'd0, 5'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 5'd0, 4'd0, 1'b1, 5'd4, 4'd2, 32'h11, 5'd0, 5'd0);
        tick();
        readRegs(5'd4, 5'd0);
        checkOutput("stale_commit_Vj", dec_Vj_out, 32'h11);
        checkOutput("stale_commit_Qj", {28'h0, dec_Qj_out}, 32'd5);
        applyStimulus(1'b0, 1'b0, 5'd0, 4'd0, 1'b1, 5'd4, 4'd5, 32'h22, 5'd0, 5'd0);
        tick();
        readRegs(5'd0, 5'd4);
        checkOutput("live_commit_Vk", dec_Vk_out, 32'h22);
        checkOutput("live_commit_Qk", {28'h0, dec_Qk_out}, 32'h0);

        // Same-cycle commit and issue to x6: value from commit, tag from issue
        applyStimulus(1'b0, 1'b1, 5'd6, 4'd9, 1'b1, 5'd6, 4'd1, 32'h33, 5'd0, 5'd0);
        tick();
        readRegs(5'd6, 5'd0);
        checkOutput("issue_commit_Vj", dec_Vj_out, 32'h33);
        checkOutput("issue_commit_Qj", {28'h0, dec_Qj_out}, 32'd9);

        // Writes to x0 are discarded
        applyStimulus(1'b0, 1'b1, 5'd0, 4'd4, 1'b1, 5'd0, 4'd0, 32'hFF, 5'd0, 5'd0);
        tick();
        readRegs(5'd0, 5'd0);
        checkOutput("x0_Vj", dec_Vj_out, 32'h0);
        checkOutput("x0_Qj", {28'h0, dec_Qj_out}, 32'h0);

        // Tag x1..x8 with tags 1..8
        for (int r = 1; r <= 8; r++) begin
            applyStimulus(1'b0, 1'b1, 5'(r), 4'(r), 1'b0, 5'd0, 4'd0, 32'h0, 5'd0, 5'd0);
            tick();
        end
        readRegs(5'd8, 5'd2);
        checkOutput("pre_roll_Qj_x8", {28'h0, dec_Qj_out}, 32'd8);
        checkOutput("pre_roll_Qk_x2", {28'h0, dec_Qk_out}, 32'd2);

        // Rollback with a same-cycle commit (kept) and issue (dropped)
        applyStimulus(1'b1, 1'b1, 5'd9, 4'd10, 1'b1, 5'd2, 4'd2, 32'h44, 5'd0, 5'd0);
        tick();
        readRegs(5'd2, 5'd9);
        checkOutput("roll_commit_Vj_x2", dec_Vj_out, 32'h44);
        checkOutput("roll_Qj_x2", {28'h0, dec_Qj_out}, 32'h0);
        checkOutput("roll_issue_Qk_x9", {28'h0, dec_Qk_out}, 32'h0);
        checkOutput("roll_Vk_x9", dec_Vk_out, 32'h0);
        readRegs(5'd3, 5'd6);
        checkOutput("roll_Vj_x3", dec_Vj_out, 32'hDEAD_BEEF);
        checkOutput("roll_Qj_x3", {28'h0, dec_Qj_out}, 32'h0);
        checkOutput("roll_Vk_x6", dec_Vk_out, 32'h33);
        checkOutput("roll_Qk_x6", {28'h0, dec_Qk_out}, 32'h0);
        readRegs(5'd8, 5'd4);
        checkOutput("roll_Qj_x8", {28'h0, dec_Qj_out}, 32'h0);
        checkOutput("roll_Vk_x4", dec_Vk_out, 32'h22);

        // Same-cycle commit to x7 observed on rs2
        applyStimulus(1'b0, 1'b1, 5'd7, 4'd3, 1'b0, 5'd0, 4'd0, 32'h0, 5'd0, 5'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 5'd0, 4'd0, 1'b1, 5'd7, 4'd3, 32'h55, 5'd0, 5'd7);
`ifdef REGFILE_COMMIT_BYPASS_EN
        checkOutput("bypass_Vk_x7", dec_Vk_out, 32'h55);
        checkOutput("bypass_Qk_x7", {28'h0, dec_Qk_out}, 32'h0);
`else
        checkOutput("nobypass_Vk_x7", dec_Vk_out, 32'h0);
        checkOutput("nobypass_Qk_x7", {28'h0, dec_Qk_out}, 32'd3);
`endif
        tick();
        readRegs(5'd0, 5'd7);
        checkOutput("post_commit_Vk_x7", dec_Vk_out, 32'h55);
        checkOutput("post_commit_Qk_x7", {28'h0, dec_Qk_out}, 32'h0);

        // Synchronous reset clears everything at the next edge
        rst = 1'b1;
        readRegs(5'd3, 5'd7);
        tick();
        rst = 1'b0;
        readRegs(5'd3, 5'd7);
        checkOutput("rereset_Vj_x3", dec_Vj_out, 32'h0);
        checkOutput("rereset_Vk_x7", dec_Vk_out, 32'h0);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
